// File: rtl/tinycore_pkg.sv
// Shared definitions for the tiny accumulator core: opcodes, run-state encodings, default widths.
package tinycore_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_STR = 3'b101;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } run_state_e;

  // Saturating 4-bit increment toward a ceiling.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] ceil);
    sat_inc4 = (v >= ceil) ? ceil : v + 4'd1;
  endfunction

endpackage

// File: rtl/tinycore_imem.sv
// Single-port synchronous instruction RAM; read data registered and held when not reading.
module tinycore_imem
  import tinycore_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;

  // Read register keeps the last fetched word until the next granted read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Memory array is never reset; only the write port touches it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read data register, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tinycore_imem_sched.sv
// Run controller (HALT/RUN/STEP) and fetch/load arbiter for the shared instruction memory.
module tinycore_imem_sched
  import tinycore_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          cmd_run,
  input  logic          cmd_halt,
  input  logic          cmd_step,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_stall,
  output logic          core_en,
  output logic [1:0]    run_state
);

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] STEP_LOAD_C = 4'(STEP_CYCLES - 1);

  run_state_e state_d, state_q;
  logic [3:0] wait_cnt_d, wait_cnt_q;
  logic [3:0] step_cnt_d, step_cnt_q;
  logic       core_en_d, core_en_q;
  logic       fetch_valid_d, fetch_valid_q;
  logic       act;
  logic       mem_we;
  logic       fetch_grant;

  // Arbitration: one memory access per cycle; nothing is granted while frozen or in reset.
  always_comb begin
    act         = ena & rst_n;
    ld_ready    = 1'b0;
    fetch_grant = 1'b0;
    if (act) begin
      if (state_q == ST_HALT) begin
        ld_ready    = 1'b1;
        fetch_grant = fetch_req & ~ld_valid;
      end else begin
        ld_ready    = ~fetch_req | (wait_cnt_q == MAX_WAIT_C);
        // A forced load slot steals the cycle from the fetch.
        fetch_grant = fetch_req & ~(ld_valid & ld_ready);
      end
    end
    mem_we      = ld_valid & ld_ready;
    fetch_stall = act & fetch_req & ~fetch_grant;
  end

  // Next-state for run FSM, step/wait counters, core enable and fetch valid.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    step_cnt_d    = step_cnt_q;
    core_en_d     = core_en_q;
    fetch_valid_d = 1'b0;
    if (ena) begin
      fetch_valid_d = fetch_grant;
      if (!ld_valid || ld_ready) wait_cnt_d = '0;
      else                       wait_cnt_d = sat_inc4(wait_cnt_q, MAX_WAIT_C);
      if (cmd_halt) begin
        state_d = ST_HALT;
      end else begin
        unique case (state_q)
          ST_HALT: begin
            if (cmd_step) begin
              state_d    = ST_STEP;
              step_cnt_d = STEP_LOAD_C;
            end else if (cmd_run) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: state_d = ST_RUN;
          ST_STEP: begin
            if (cmd_run)                  state_d = ST_RUN;
            else if (step_cnt_q == 4'd0)  state_d = ST_HALT;
            else                          step_cnt_d = step_cnt_q - 4'd1;
          end
          default: state_d = ST_HALT;
        endcase
      end
      core_en_d = (state_d != ST_HALT);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HALT;
      wait_cnt_q    <= '0;
      step_cnt_q    <= '0;
      core_en_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      step_cnt_q    <= step_cnt_d;
      core_en_q     <= core_en_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  tinycore_imem #(
    .AW   (AW),
    .DEPTH(DEPTH),
    .DW   (DW)
  ) u_imem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .re   (fetch_grant),
    .addr (mem_we ? ld_addr : fetch_addr),
    .wdata(ld_data),
    .rdata(fetch_data)
  );

  assign core_en     = core_en_q;
  assign fetch_valid = fetch_valid_q;
  assign run_state   = state_q;

endmodule

// File: tb/tb_tinycore_imem_sched.sv
// Randomised + directed bench for tinycore_imem_sched with a behavioural model and fetch scoreboard.
module tb_tinycore_imem_sched;

  localparam int MAX_WAIT    = 4;
  localparam int STEP_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_run, cmd_halt, cmd_step;
  logic       ld_valid, ld_ready, fetch_req, fetch_valid, fetch_stall, core_en;
  logic [3:0] ld_addr, fetch_addr;
  logic [7:0] ld_data, fetch_data;
  logic [1:0] run_state;

  always #5 clk = ~clk;

  tinycore_imem_sched #(
    .AW(4), .DEPTH(16), .DW(8), .MAX_WAIT(MAX_WAIT), .STEP_CYCLES(STEP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
    .core_en(core_en), .run_state(run_state)
  );

  int checks = 0;
  int failures = 0;

  // stimulus for the next cycle
  bit s_rst = 1'b0, s_ena = 1'b1, s_run, s_halt, s_step, s_lv, s_fr;
  logic [3:0] s_la, s_fa;
  logic [7:0] s_ld;

  // reference model: 0=HALT 1=RUN 2=STEP; steps_left counts remaining enabled step cycles
  int   m_state = 0;
  int   m_wait = 0;
  int   m_left = 0;
  bit   m_core_en = 0, m_fv = 0;
  logic [7:0] mem_m [16];
  logic [7:0] exp_q [$];

  // sampled DUT values from the last tick
  bit t_rdy, t_ce;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit eff, rdy, gr, stall;
    @(negedge clk);
    rst_n = s_rst; ena = s_ena; cmd_run = s_run; cmd_halt = s_halt; cmd_step = s_step;
    ld_valid = s_lv; ld_addr = s_la; ld_data = s_ld; fetch_req = s_fr; fetch_addr = s_fa;
    #1;
    eff = s_rst && s_ena;
    if (!eff) begin
      rdy = 0; gr = 0;
    end else if (m_state == 0) begin
      rdy = 1; gr = s_fr && !s_lv;
    end else begin
      rdy = !s_fr || (m_wait == MAX_WAIT);
      gr  = s_fr && !(s_lv && rdy);
    end
    stall = eff && s_fr && !gr;
    if (s_rst) begin
      chk("ld_ready", ld_ready, rdy);
      chk("fetch_stall", fetch_stall, stall);
    end
    t_rdy = ld_ready;
    if (!s_rst) begin
      m_state = 0; m_wait = 0; m_left = 0; m_core_en = 0; m_fv = 0;
    end else if (!s_ena) begin
      m_fv = 0;
    end else begin
      if (s_lv && rdy) mem_m[s_la] = s_ld;
      if (gr) exp_q.push_back(mem_m[s_fa]);
      m_fv = gr;
      if (!s_lv || rdy) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (s_halt) m_state = 0;
      else if (m_state == 0) begin
        if (s_step) begin m_state = 2; m_left = STEP_CYCLES; end
        else if (s_run) m_state = 1;
      end else if (m_state == 2) begin
        if (s_run) m_state = 1;
        else begin
          m_left--;
          if (m_left == 0) m_state = 0;
        end
      end
      m_core_en = (m_state != 0);
    end
    @(posedge clk);
    #1;
    chk("run_state", run_state, m_state);
    chk("core_en", core_en, m_core_en);
    chk("fetch_valid", fetch_valid, m_fv);
    t_ce = core_en;
  endtask

  task automatic clear_cmds();
    s_run = 0; s_halt = 0; s_step = 0;
  endtask

  // scoreboard monitor: compare every presented fetch word with the oldest expected one
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("sb_data", fetch_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int ce_cnt, hit;
    clear_cmds(); s_lv = 0; s_fr = 0; s_la = '0; s_fa = '0; s_ld = '0;
    // power-on reset
    s_rst = 0; tick(); tick(); s_rst = 1;
    // fill memory in HALT; addr0/addr1 get known words
    for (int a = 0; a < 16; a++) begin
      s_lv = 1; s_la = 4'(a);
      s_ld = (a == 0) ? 8'h41 : (a == 1) ? 8'h02 : 8'($urandom);
      tick();
      chk("halt_ld_ready", t_rdy, 1);
    end
    s_lv = 0; s_fr = 1; s_fa = 4'd1; tick();
    chk("halt_fetch_data", fetch_data, 8'h02);
    s_fr = 0; tick();
    // single step; a second step mid-step is ignored
    ce_cnt = 0;
    s_step = 1; tick(); ce_cnt += int'(t_ce);
    tick(); ce_cnt += int'(t_ce);
    s_step = 0;
    for (int i = 0; i < 3; i++) begin tick(); ce_cnt += int'(t_ce); end
    chk("step_core_en_cycles", ce_cnt, STEP_CYCLES);
    // reset held two cycles mid-step
    s_step = 1; tick(); s_step = 0;
    s_rst = 0; tick(); tick(); s_rst = 1; tick();
    // run contention: forced load slot after MAX_WAIT stalled cycles
    s_run = 1; tick(); s_run = 0;
    s_fr = 1; s_lv = 1; s_la = 4'd5; s_ld = 8'($urandom); hit = 0;
    for (int i = 1; i <= 6; i++) begin
      s_fa = 4'($urandom);
      tick();
      if (t_rdy && hit == 0) hit = i;
    end
    chk("run_forced_slot_cycle", hit, MAX_WAIT + 1);
    s_fr = 0; s_lv = 0; tick();
    // command priority
    s_halt = 1; s_run = 1; tick(); clear_cmds();
    s_step = 1; tick(); clear_cmds();
    s_run = 1; tick(); clear_cmds();
    chk("step_to_run_core_en", t_ce, 1);
    // freeze mid-contention, then resume where left off
    s_fr = 1; s_lv = 1; s_la = 4'd9; s_ld = 8'($urandom);
    tick(); tick();
    s_ena = 0; s_run = 1; tick(); tick(); tick(); s_run = 0; s_ena = 1;
    hit = 0;
    for (int i = 1; i <= 4; i++) begin
      s_fa = 4'($urandom);
      tick();
      if (t_rdy && hit == 0) hit = i;
    end
    chk("resume_forced_slot_cycle", hit, 3);
    s_fr = 0; s_lv = 0; tick();
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      s_rst  = ($urandom_range(0, 99) != 0);
      s_ena  = ($urandom_range(0, 9) != 0);
      s_run  = ($urandom_range(0, 19) == 0);
      s_halt = ($urandom_range(0, 29) == 0);
      s_step = ($urandom_range(0, 14) == 0);
      s_lv   = ($urandom_range(0, 1) == 1);
      s_fr   = ($urandom_range(0, 9) < 6);
      s_la   = 4'($urandom); s_fa = 4'($urandom); s_ld = 8'($urandom);
      tick();
    end
    s_rst = 1; s_ena = 1; clear_cmds(); s_lv = 0; s_fr = 0;
    tick(); tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
